read_buffer_controller: RTL and testbench
=========================================

# read_buffer_controller

Read-side controller for the input buffer feeding the processing element (PE). On a PE request it fetches a burst of `BURST` words from the buffer, which has a one-cycle read latency. It stalls the PE while the buffer is empty and delivers registered data with valid and last-of-burst flags. It is the consumer-side counterpart of the write-side controller that moves PE results into the output buffer.

## Interface
- `DATA_W`, 16: buffer/PE data width.
- `BURST`, 4: words per request; legal range 1..255.
- `CNT_W`, 8: burst counter width; must hold `BURST-1`.

- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: global enable; sampled only in IDLE.
- `req` input, 1 bit: PE requests one burst (level); sampled only in IDLE.
- `empty` input, 1 bit: input buffer has no readable word.
- `buf_dout` input, `DATA_W` bits: buffer read data, valid one cycle after `read_from_buffer`.
- `read_from_buffer` output, 1 bit: buffer read strobe, combinational from state and `empty`.
- `stall_pe` output, 1 bit: high while a burst is waiting on an empty buffer.
- `pe_data` output, `DATA_W` bits: registered word to the PE.
- `pe_valid` output, 1 bit: `pe_data` is valid this cycle.
- `pe_last` output, 1 bit: qualifies the final `pe_valid` of a burst.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- States: IDLE=2'd0, FETCH=2'd1, STALL=2'd2, DONE=2'd3. The state register resets to IDLE.
- **IDLE**
  - If `start & req & ~empty`, go to FETCH.
  - If `start & req & empty`, go to STALL.
  - Otherwise stay in IDLE.
- **FETCH**
  - `read_from_buffer = ~empty`.
  - If `empty`, go to STALL; no read is issued and `cnt` holds.
  - If `~empty` and `cnt==BURST-1`, go to DONE.
  - If `~empty` and `cnt<BURST-1`, increment `cnt` and stay in FETCH.
- **STALL**
  - `stall_pe=1`, `read_from_buffer=0`.
  - If `~empty`, go to FETCH; otherwise stay.
- **DONE**
  - `cnt` clears to 0.
  - Unconditionally go to IDLE. A still-high `req` starts a new burst from IDLE one cycle later.
- `start` and `req` are ignored outside IDLE. Deasserting either mid-burst does not abort the burst.
- Data pipeline:
  - `rd_d <= read_from_buffer`.
  - `last_d <= read_from_buffer & (cnt==BURST-1)`.
  - When `rd_d`: `pe_data <= buf_dout`, `pe_valid <= 1`, `pe_last <= last_d`.
  - Otherwise `pe_valid <= 0` and `pe_last <= 0`; `pe_data` holds.
- Exactly `BURST` `pe_valid` pulses occur per burst, and exactly one carries `pe_last`.

## Timing
- Reset values:
  - `ps`=IDLE, `cnt`=0, `rd_d`=0, `last_d`=0.
  - `pe_valid`=0, `pe_last`=0, `pe_data`=0.
  - `read_from_buffer`, `stall_pe` and `busy` are 0 as a consequence of IDLE.
- Reset mid-burst:
  - All state clears on the next edge, including in-flight `rd_d` and `last_d`.
  - No `pe_valid` follows reset.
  - Buffer words already popped are lost; this is acceptable.
- Latency from request to data: `req` sampled at edge T with buffer non-empty gives the first read at T+1, `buf_dout` at T+2, and `pe_valid` at T+3.
- With no stalls, a burst occupies FETCH for `BURST` cycles, then one DONE cycle. `pe_last` appears 2 cycles after the last read.
- `empty` rising in FETCH takes effect in the same cycle: no read is issued that cycle.
- `BURST=1`: the single read takes FETCH to DONE directly, and `pe_last` coincides with the only `pe_valid`.
- Back-to-back bursts have a minimum gap of 2 non-reading cycles (DONE, then IDLE).

## Structure
- Shared package holds:
  - the state encodings `IDLE`, `FETCH`, `STALL`, `DONE`;
  - the default `BURST` and `DATA_W` constants used by the PE and buffer.
- Single module, with no sub-module. The output pipeline (`rd_d`/`last_d` to `pe_*`) is an always block inside this module, not a separate instance.

## Test plan
- Reset, then idle with `start=0`, `req=1`, `empty=0` for 10 cycles:
  - Required: `read_from_buffer=0`, `busy=0`, `pe_valid=0` throughout.
- `BURST=4`, buffer holding 0xA1..0xA4, `start=req=1` at cycle 0:
  - Required: reads at cycles 1–4, `pe_valid` at cycles 3–6 with data A1..A4, `pe_last` only at cycle 6.
- `empty=1` at request, then `empty=0` at cycle 5:
  - Required: `stall_pe=1` for cycles 1–5, first read at cycle 6.
- `empty` goes high for cycles 3–4 mid-burst (after 2 reads):
  - Required: no read in cycles 3–4, STALL in cycle 4.
  - Required: remaining 2 reads, exactly 4 `pe_valid` pulses total, one `pe_last`.
- `rst` asserted one cycle after the third read:
  - Required: all outputs 0 on the next edge, no further `pe_valid`.
  - Required: a new request afterwards completes a full 4-word burst.
- `BURST=1` with `req` held high, buffer always non-empty:
  - Required: reads every 3 cycles.
  - Required: every `pe_valid` has `pe_last=1`.

Source files
------------

// File: rtl/read_buffer_controller_pkg.sv
// Shared definitions for the PE input-buffer read controller: FSM state
// encodings and the default burst/data geometry agreed with the PE and buffer.
package read_buffer_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_BURST  = 4;
    localparam int DEFAULT_CNT_W  = 8;

    // Terminal count of the burst counter, sized to the counter width.
    function automatic logic [DEFAULT_CNT_W-1:0] burst_last(input int burst);
        return DEFAULT_CNT_W'(burst - 1);
    endfunction

endpackage

// File: rtl/read_buffer_controller_if.sv
// PE/buffer-side signal bundle of the read controller. The slave modport is the
// controller's view; the master modport is the PE/buffer environment's view.
interface read_buffer_controller_if
    import read_buffer_controller_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              start;
    logic              req;
    logic              empty;
    logic [DATA_W-1:0] buf_dout;
    logic              read_from_buffer;
    logic              stall_pe;
    logic [DATA_W-1:0] pe_data;
    logic              pe_valid;
    logic              pe_last;
    logic              busy;

    modport slave (
        input  start,
        input  req,
        input  empty,
        input  buf_dout,
        output read_from_buffer,
        output stall_pe,
        output pe_data,
        output pe_valid,
        output pe_last,
        output busy
    );

    modport master (
        output start,
        output req,
        output empty,
        output buf_dout,
        input  read_from_buffer,
        input  stall_pe,
        input  pe_data,
        input  pe_valid,
        input  pe_last,
        input  busy
    );

endinterface

// File: rtl/read_buffer_controller.sv
// Fetches BURST words from the one-cycle-latency input buffer per PE request,
// stalling the PE while the buffer is empty, and presents registered data.
module read_buffer_controller
    import read_buffer_controller_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int BURST  = DEFAULT_BURST,
    parameter int CNT_W  = DEFAULT_CNT_W
)(
    input  logic                     clk,
    input  logic                     rst,
    read_buffer_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cnt_at_last;
    logic               rd;
    logic               stall;

    logic               rd_dly_q;
    logic               last_dly_q;
    logic [DATA_W-1:0]  pe_data_q;
    logic               pe_valid_q;
    logic               pe_last_q;

    assign cnt_at_last = (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd      = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.req) begin
                    state_d = bus.empty ? STALL : FETCH;
                end
            end
            FETCH: begin
                // An empty buffer suppresses the read in the same cycle; cnt holds.
                if (bus.empty) begin
                    state_d = STALL;
                end else begin
                    rd = 1'b1;
                    if (cnt_at_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (!bus.empty) begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output pipeline: the strobe and last flag are delayed to line up with
    // buf_dout, which arrives one cycle after the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dly_q   <= 1'b0;
            last_dly_q <= 1'b0;
            pe_data_q  <= '0;
            pe_valid_q <= 1'b0;
            pe_last_q  <= 1'b0;
        end else begin
            rd_dly_q   <= rd;
            last_dly_q <= rd & cnt_at_last;
            if (rd_dly_q) begin
                pe_data_q  <= bus.buf_dout;
                pe_valid_q <= 1'b1;
                pe_last_q  <= last_dly_q;
            end else begin
                pe_valid_q <= 1'b0;
                pe_last_q  <= 1'b0;
            end
        end
    end

    assign bus.read_from_buffer = rd;
    assign bus.stall_pe         = stall;
    assign bus.pe_data          = pe_data_q;
    assign bus.pe_valid         = pe_valid_q;
    assign bus.pe_last          = pe_last_q;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_read_buffer_controller.sv
// Directed bench for read_buffer_controller: a BURST=4 instance and a BURST=1
// instance, each fed by a one-cycle-latency buffer model returning A1, A2, ...
module tb_read_buffer_controller;

    logic clk;
    logic rst;
    logic buf_clr;

    int tests_run;
    int tests_failed;
    int cyc;

    read_buffer_controller_if #(.DATA_W(16)) bus4 ();
    read_buffer_controller_if #(.DATA_W(16)) bus1 ();

    read_buffer_controller #(.DATA_W(16), .BURST(4), .CNT_W(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    read_buffer_controller #(.DATA_W(16), .BURST(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Buffer models: word n popped since the last clear reads back as 0x00A1+n.
    logic [15:0] ptr4, ptr1;

    always @(posedge clk) begin
        if (buf_clr) begin
            ptr4          <= '0;
            bus4.buf_dout <= '0;
        end else if (bus4.read_from_buffer) begin
            bus4.buf_dout <= 16'h00A1 + ptr4;
            ptr4          <= ptr4 + 16'd1;
        end
    end

    always @(posedge clk) begin
        if (buf_clr) begin
            ptr1          <= '0;
            bus1.buf_dout <= '0;
        end else if (bus1.read_from_buffer) begin
            bus1.buf_dout <= 16'h00A1 + ptr1;
            ptr1          <= ptr1 + 16'd1;
        end
    end

    // Per-cycle trace, bit k = value seen mid-cycle k of the current scenario.
    logic [31:0] rd4, val4, last4, stall4, busy4;
    logic [31:0] rd1, val1, last1;
    logic [15:0] data4 [32];
    logic [15:0] data1 [32];

    function automatic logic [31:0] upd(input logic [31:0] v, input logic b, input int c);
        logic [31:0] base;
        base    = (c == 0) ? 32'd0 : v;
        base[c] = b;
        return base;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < 32) begin
            rd4       <= upd(rd4,    bus4.read_from_buffer, cyc);
            val4      <= upd(val4,   bus4.pe_valid,         cyc);
            last4     <= upd(last4,  bus4.pe_last,          cyc);
            stall4    <= upd(stall4, bus4.stall_pe,         cyc);
            busy4     <= upd(busy4,  bus4.busy,             cyc);
            rd1       <= upd(rd1,    bus1.read_from_buffer, cyc);
            val1      <= upd(val1,   bus1.pe_valid,         cyc);
            last1     <= upd(last1,  bus1.pe_last,          cyc);
            data4[cyc] <= bus4.pe_data;
            data1[cyc] <= bus1.pe_data;
        end
    end

    task automatic clear_buffers();
        @(posedge clk); #1;
        buf_clr = 1'b1;
        @(posedge clk); #1;
        buf_clr = 1'b0;
    endtask

    task automatic end_trace();
        @(negedge clk); #1;
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        buf_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus4.read_from_buffer, bus4.stall_pe, bus4.pe_valid, bus4.pe_last, bus4.busy} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl4: got %b expected 00000", {bus4.read_from_buffer, bus4.stall_pe, bus4.pe_valid, bus4.pe_last, bus4.busy});
        end
        tests_run++;
        if (bus4.pe_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data4: got %h expected 0000", bus4.pe_data);
        end
        tests_run++;
        if ({bus1.read_from_buffer, bus1.stall_pe, bus1.pe_valid, bus1.pe_last, bus1.busy, bus1.pe_data} !== 21'b0) begin
            tests_failed++;
            $display("FAIL reset_dut1: got %h expected 0", {bus1.read_from_buffer, bus1.stall_pe, bus1.pe_valid, bus1.pe_last, bus1.busy, bus1.pe_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        buf_clr = 1'b0;
    endtask

    task automatic test_idle_no_start();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            cyc = k;
            bus4.start = 1'b0;
            bus4.req   = 1'b1;
            bus4.empty = 1'b0;
        end
        end_trace();
        bus4.req = 1'b0;
        tests_run++;
        if (rd4[9:0] !== 10'd0) begin
            tests_failed++;
            $display("FAIL idle_rd: got %b expected 0000000000", rd4[9:0]);
        end
        tests_run++;
        if (busy4[9:0] !== 10'd0) begin
            tests_failed++;
            $display("FAIL idle_busy: got %b expected 0000000000", busy4[9:0]);
        end
        tests_run++;
        if (val4[9:0] !== 10'd0) begin
            tests_failed++;
            $display("FAIL idle_valid: got %b expected 0000000000", val4[9:0]);
        end
    endtask

    task automatic run_burst4(input string tag);
        clear_buffers();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (k == 0) begin
                bus4.start = 1'b1;
                bus4.req   = 1'b1;
                bus4.empty = 1'b0;
            end
            if (k == 2) begin
                bus4.start = 1'b0;
                bus4.req   = 1'b0;
            end
        end
        end_trace();
        tests_run++;
        if (rd4[11:0] !== 12'h01E) begin
            tests_failed++;
            $display("FAIL %s_rd: got %h expected 01e", tag, rd4[11:0]);
        end
        tests_run++;
        if (val4[11:0] !== 12'h078) begin
            tests_failed++;
            $display("FAIL %s_valid: got %h expected 078", tag, val4[11:0]);
        end
        tests_run++;
        if (last4[11:0] !== 12'h040) begin
            tests_failed++;
            $display("FAIL %s_last: got %h expected 040", tag, last4[11:0]);
        end
        tests_run++;
        if (busy4[11:0] !== 12'h03E) begin
            tests_failed++;
            $display("FAIL %s_busy: got %h expected 03e", tag, busy4[11:0]);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (data4[3 + i] !== 16'h00A1 + 16'(i)) begin
                tests_failed++;
                $display("FAIL %s_data%0d: got %h expected %h", tag, i, data4[3 + i], 16'h00A1 + 16'(i));
            end
        end
    endtask

    task automatic test_burst4();
        run_burst4("burst4");
    endtask

    task automatic test_stall_at_request();
        clear_buffers();
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (k == 0) begin
                bus4.start = 1'b1;
                bus4.req   = 1'b1;
                bus4.empty = 1'b1;
            end
            if (k == 2) begin
                bus4.start = 1'b0;
                bus4.req   = 1'b0;
            end
            if (k == 5) bus4.empty = 1'b0;
        end
        end_trace();
        tests_run++;
        if (stall4[13:0] !== 14'h003E) begin
            tests_failed++;
            $display("FAIL stallreq_stall: got %h expected 003e", stall4[13:0]);
        end
        tests_run++;
        if (rd4[13:0] !== 14'h03C0) begin
            tests_failed++;
            $display("FAIL stallreq_rd: got %h expected 03c0", rd4[13:0]);
        end
        tests_run++;
        if (val4[13:0] !== 14'h0F00) begin
            tests_failed++;
            $display("FAIL stallreq_valid: got %h expected 0f00", val4[13:0]);
        end
        tests_run++;
        if (last4[13:0] !== 14'h0800) begin
            tests_failed++;
            $display("FAIL stallreq_last: got %h expected 0800", last4[13:0]);
        end
        tests_run++;
        if (data4[8] !== 16'h00A1 || data4[11] !== 16'h00A4) begin
            tests_failed++;
            $display("FAIL stallreq_data: got %h,%h expected 00a1,00a4", data4[8], data4[11]);
        end
    endtask

    task automatic test_mid_burst_stall();
        clear_buffers();
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (k == 0) begin
                bus4.start = 1'b1;
                bus4.req   = 1'b1;
                bus4.empty = 1'b0;
            end
            if (k == 2) begin
                bus4.start = 1'b0;
                bus4.req   = 1'b0;
            end
            if (k == 3) bus4.empty = 1'b1;
            if (k == 5) bus4.empty = 1'b0;
        end
        end_trace();
        tests_run++;
        if (rd4[13:0] !== 14'h00C6) begin
            tests_failed++;
            $display("FAIL midstall_rd: got %h expected 00c6", rd4[13:0]);
        end
        tests_run++;
        if (stall4[13:0] !== 14'h0030) begin
            tests_failed++;
            $display("FAIL midstall_stall: got %h expected 0030", stall4[13:0]);
        end
        tests_run++;
        if (val4[13:0] !== 14'h0318) begin
            tests_failed++;
            $display("FAIL midstall_valid: got %h expected 0318", val4[13:0]);
        end
        tests_run++;
        if (last4[13:0] !== 14'h0200) begin
            tests_failed++;
            $display("FAIL midstall_last: got %h expected 0200", last4[13:0]);
        end
        tests_run++;
        if ({data4[3], data4[4], data4[8], data4[9]} !== {16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4}) begin
            tests_failed++;
            $display("FAIL midstall_data: got %h %h %h %h expected 00a1 00a2 00a3 00a4", data4[3], data4[4], data4[8], data4[9]);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_buffers();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (k == 0) begin
                bus4.start = 1'b1;
                bus4.req   = 1'b1;
                bus4.empty = 1'b0;
            end
            if (k == 2) begin
                bus4.start = 1'b0;
                bus4.req   = 1'b0;
            end
            if (k == 4) rst = 1'b1;
            if (k == 5) rst = 1'b0;
        end
        end_trace();
        tests_run++;
        if (rd4[11:0] !== 12'h01E) begin
            tests_failed++;
            $display("FAIL rstmid_rd: got %h expected 01e", rd4[11:0]);
        end
        tests_run++;
        if (val4[11:0] !== 12'h018) begin
            tests_failed++;
            $display("FAIL rstmid_valid: got %h expected 018", val4[11:0]);
        end
        tests_run++;
        if (last4[11:0] !== 12'h000) begin
            tests_failed++;
            $display("FAIL rstmid_last: got %h expected 000", last4[11:0]);
        end
        tests_run++;
        if (busy4[11:0] !== 12'h01E) begin
            tests_failed++;
            $display("FAIL rstmid_busy: got %h expected 01e", busy4[11:0]);
        end
        tests_run++;
        if (data4[5] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_data: got %h expected 0000", data4[5]);
        end
        run_burst4("after_rst");
    endtask

    task automatic test_burst1_back_to_back();
        clear_buffers();
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (k == 0) begin
                bus1.start = 1'b1;
                bus1.req   = 1'b1;
                bus1.empty = 1'b0;
            end
            if (k == 12) begin
                bus1.start = 1'b0;
                bus1.req   = 1'b0;
            end
        end
        end_trace();
        tests_run++;
        if (rd1[12:0] !== 13'h0492) begin
            tests_failed++;
            $display("FAIL burst1_rd: got %h expected 0492", rd1[12:0]);
        end
        tests_run++;
        if (val1[12:0] !== 13'h1248) begin
            tests_failed++;
            $display("FAIL burst1_valid: got %h expected 1248", val1[12:0]);
        end
        tests_run++;
        if (last1[12:0] !== 13'h1248) begin
            tests_failed++;
            $display("FAIL burst1_last: got %h expected 1248", last1[12:0]);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (data1[3 + 3 * i] !== 16'h00A1 + 16'(i)) begin
                tests_failed++;
                $display("FAIL burst1_data%0d: got %h expected %h", i, data1[3 + 3 * i], 16'h00A1 + 16'(i));
            end
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = -1;
        rst          = 1'b1;
        buf_clr      = 1'b1;
        bus4.start = 1'b0; bus4.req = 1'b0; bus4.empty = 1'b0;
        bus1.start = 1'b0; bus1.req = 1'b0; bus1.empty = 1'b0;

        test_reset();
        test_idle_no_start();
        test_burst4();
        test_stall_at_request();
        test_mid_burst_stall();
        test_reset_mid_burst();
        test_burst1_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
